uart_bus_arbiter: RTL and testbench

Two-master arbiter sharing the single UART register port (`uart_wrap` data interface) between two requesters, e.g. two cores in a multicore build. Round-robin grant per transaction, one outstanding transaction at a time, response steered back to the owning requester. An optional line lock keeps one requester's text lines from interleaving with the other's.

---
 rtl/uart_bus_arbiter.sv | 135 +++++++++++++
 tb/tb_uart_bus_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_arbiter.sv
// Round-robin arbiter sharing one uart_wrap register port between two requesters.
// Optional text-line lock enabled by defining UART_ARB_LINE_LOCK_EN.
module uart_bus_arbiter #(
  parameter int ADDR_WIDTH = 4
`ifdef UART_ARB_LINE_LOCK_EN
  ,
  parameter logic [ADDR_WIDTH-1:0] TX_ADDR = '0,
  parameter int LOCK_TIMEOUT = 1023
`endif
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic [1:0]                 req_i,
  output logic [1:0]                 gnt_o,
  output logic [1:0]                 rvalid_o,
  input  logic [1:0]                 we_i,
  input  logic [1:0][3:0]            be_i,
  input  logic [1:0][ADDR_WIDTH-1:0] addr_i,
  input  logic [1:0][31:0]           wdata_i,
  output logic [31:0]                rdata_o,
  output logic                       uart_req_o,
  input  logic                       uart_gnt_i,
  input  logic                       uart_rvalid_i,
  output logic                       uart_we_o,
  output logic [3:0]                 uart_be_o,
  output logic [ADDR_WIDTH-1:0]      uart_addr_o,
  output logic [31:0]                uart_wdata_o,
  input  logic [31:0]                uart_rdata_i,
  output logic                       busy_o
);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t state, state_d;
  logic   last;
  logic   owner;
  logic   win;
  logic   grant;
  logic   resp_done;

`ifdef UART_ARB_LINE_LOCK_EN
  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
  logic             lock;
  logic             lock_owner;
  logic [CNT_W-1:0] lock_cnt;
  logic             tx_char;
  logic             is_newline;
`endif

  // NOTE: every variable assigned in an always_comb gets a default first,
  // so no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    win = 1'b0;
    if (req_i == 2'b11) win = ~last;
    else if (req_i[1])  win = 1'b1;
`ifdef UART_ARB_LINE_LOCK_EN
    if (lock) win = lock_owner;
`endif
  end

  // The request is masked during reset so nothing reaches the UART port.
  assign uart_req_o   = rstn_i && (state == IDLE) && req_i[win];
  assign grant        = uart_req_o & uart_gnt_i;
  assign resp_done    = (state == RESP) & uart_rvalid_i;
  assign uart_we_o    = we_i[win];
  assign uart_be_o    = be_i[win];
  assign uart_addr_o  = addr_i[win];
  assign uart_wdata_o = wdata_i[win];
  assign rdata_o      = uart_rdata_i;

  always_comb begin
    gnt_o    = 2'b00;
    rvalid_o = 2'b00;
    if (grant)     gnt_o[win]      = 1'b1;
    if (resp_done) rvalid_o[owner] = 1'b1;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (grant)         state_d = RESP;
      RESP:    if (uart_rvalid_i) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= IDLE;
      last  <= 1'b1;
      owner <= 1'b0;
    end else begin
      state <= state_d;
      if (grant)     owner <= win;
      if (resp_done) last  <= owner;
    end
  end

`ifdef UART_ARB_LINE_LOCK_EN
  assign tx_char    = we_i[win] && (addr_i[win] == TX_ADDR) && be_i[win][0];
  assign is_newline = (wdata_i[win][7:0] == 8'h0A);

  // A granted non-newline character opens a line; the owner's newline or a
  // long silence from the owner closes it.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      lock       <= 1'b0;
      lock_owner <= 1'b0;
      lock_cnt   <= '0;
    end else if (grant) begin
      lock_cnt <= '0;
      if (tx_char && !is_newline) begin
        lock       <= 1'b1;
        lock_owner <= win;
      end else if (tx_char && lock && (win == lock_owner)) begin
        lock <= 1'b0;
      end
    end else if ((state == IDLE) && lock && !req_i[lock_owner]) begin
      if (lock_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
        lock     <= 1'b0;
        lock_cnt <= '0;
      end else begin
        lock_cnt <= lock_cnt + 1'b1;
      end
    end
  end

  assign busy_o = (state == RESP) | lock;
`else
  assign busy_o = (state == RESP);
`endif

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Self-checking bench for uart_bus_arbiter: directed scenarios plus random traffic
// compared against a transaction-level reference model.
module tb_uart_bus_arbiter;

  localparam int ADDR_WIDTH = 4;
  localparam logic [ADDR_WIDTH-1:0] TX_ADDR = 4'h0;
  localparam int LOCK_TIMEOUT = 1023;
`ifdef UART_ARB_LINE_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic                       clk_i = 1'b0;
  logic                       rstn_i;
  logic [1:0]                 req_i;
  logic [1:0]                 gnt_o;
  logic [1:0]                 rvalid_o;
  logic [1:0]                 we_i;
  logic [1:0][3:0]            be_i;
  logic [1:0][ADDR_WIDTH-1:0] addr_i;
  logic [1:0][31:0]           wdata_i;
  logic [31:0]                rdata_o;
  logic                       uart_req_o;
  logic                       uart_gnt_i;
  logic                       uart_rvalid_i;
  logic                       uart_we_o;
  logic [3:0]                 uart_be_o;
  logic [ADDR_WIDTH-1:0]      uart_addr_o;
  logic [31:0]                uart_wdata_o;
  logic [31:0]                uart_rdata_i;
  logic                       busy_o;

  uart_bus_arbiter #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .req_i(req_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .we_i(we_i), .be_i(be_i), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
    .uart_req_o(uart_req_o), .uart_gnt_i(uart_gnt_i), .uart_rvalid_i(uart_rvalid_i),
    .uart_we_o(uart_we_o), .uart_be_o(uart_be_o), .uart_addr_o(uart_addr_o),
    .uart_wdata_o(uart_wdata_o), .uart_rdata_i(uart_rdata_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: who holds the port, who went last, and the line lock.
  bit m_busy;
  int m_owner, m_last;
  bit m_lock;
  int m_lo, m_cnt;
  int gq[$];
  int gcyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int exp_winner(input logic [1:0] req);
    if (m_lock) return req[m_lo] ? m_lo : -1;
    if (req == 2'b11) return 1 - m_last;
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = 1; m_lock = 0; m_lo = 0; m_cnt = 0;
  endtask

  task automatic quiet_inputs();
    req_i = '0; we_i = '0; be_i = '0; addr_i = '0; wdata_i = '0;
    uart_gnt_i = 1'b1; uart_rvalid_i = 1'b1; uart_rdata_i = '0;
  endtask

  task automatic set_cmd(input int r, input logic we, input logic [ADDR_WIDTH-1:0] a,
                         input logic [31:0] d);
    we_i[r] = we; be_i[r] = 4'hF; addr_i[r] = a; wdata_i[r] = d;
  endtask

  // One clock cycle: check outputs against the model, then advance the model.
  task automatic step();
    int cand;
    logic [1:0] eg, ev;
    #1;
    cand = m_busy ? -1 : exp_winner(req_i);
    eg = 2'b00;
    ev = 2'b00;
    if (cand >= 0 && uart_gnt_i) eg[cand] = 1'b1;
    if (m_busy && uart_rvalid_i) ev[m_owner] = 1'b1;
    check("uart_req", uart_req_o, cand >= 0);
    check("gnt", gnt_o, eg);
    check("rvalid", rvalid_o, ev);
    check("busy", busy_o, m_busy || m_lock);
    if (cand >= 0) begin
      check("cmd_we", uart_we_o, we_i[cand]);
      check("cmd_be", uart_be_o, be_i[cand]);
      check("cmd_addr", uart_addr_o, addr_i[cand]);
      check("cmd_wdata", uart_wdata_o, wdata_i[cand]);
    end
    if (ev != 2'b00) check("rdata", rdata_o, uart_rdata_i);
    if (cand >= 0 && uart_gnt_i) begin
      gq.push_back(cand);
      gcyc.push_back(cyc);
      m_cnt = 0;
      if (we_i[cand] && addr_i[cand] == TX_ADDR && be_i[cand][0]) begin
        if (wdata_i[cand][7:0] != 8'h0A) begin
          m_lock = LOCK_EN;
          m_lo   = cand;
        end else if (m_lock && cand == m_lo) begin
          m_lock = 0;
        end
      end
      m_busy  = 1;
      m_owner = cand;
    end else if (m_busy && uart_rvalid_i) begin
      m_busy = 0;
      m_last = m_owner;
    end else if (!m_busy && m_lock && !req_i[m_lo]) begin
      m_cnt++;
      if (m_cnt == LOCK_TIMEOUT) begin
        m_lock = 0;
        m_cnt  = 0;
      end
    end
    @(posedge clk_i);
    @(negedge clk_i);
    cyc++;
  endtask

  // Hold reset for a cycle with both requesters active; outputs must stay quiet.
  task automatic do_reset();
    rstn_i = 1'b0;
    req_i  = 2'b11;
    #1;
    check("rst_uart_req", uart_req_o, 1'b0);
    check("rst_rvalid", rvalid_o, 2'b00);
    check("rst_busy", busy_o, 1'b0);
    @(negedge clk_i);
    model_reset();
    quiet_inputs();
    rstn_i = 1'b1;
    gq.delete();
    gcyc.delete();
  endtask

  initial begin
    int n;
    logic [7:0] s0 [3];
    logic [7:0] s1 [2];
    int p0, p1, exp_order [5];
    quiet_inputs();
    model_reset();
    rstn_i = 1'b0;
    @(negedge clk_i);
    do_reset();

    // Single requester writes 'A' to TX.
    req_i = 2'b01;
    set_cmd(0, 1'b1, TX_ADDR, 32'h41);
    uart_rvalid_i = 1'b0;
    #1;
    check("single_wdata", uart_wdata_o, 32'h41);
    check("single_gnt", gnt_o, 2'b01);
    step();
    req_i = 2'b00;
    uart_rvalid_i = 1'b1;
    step();
    step();

    // Contention: reads from both, four transactions.
    do_reset();
    req_i = 2'b11;
    set_cmd(0, 1'b0, 4'h4, 32'h0);
    set_cmd(1, 1'b0, 4'h4, 32'h0);
    for (int i = 0; i < 8; i++) step();
    check("cont_count", gq.size(), 4);
    for (int i = 0; i < 4 && i < gq.size(); i++) begin
      check("cont_order", gq[i], i % 2);
      if (i > 0) check("cont_spacing", gcyc[i] - gcyc[i-1], 2);
    end

    // Read steering to requester 1.
    req_i = 2'b10;
    uart_rvalid_i = 1'b0;
    step();
    req_i = 2'b00;
    uart_rvalid_i = 1'b1;
    uart_rdata_i = 32'hDEADBEEF;
    #1;
    check("steer_rvalid", rvalid_o, 2'b10);
    check("steer_rdata", rdata_o, 32'hDEADBEEF);
    step();

    // Reset arriving while the response is pending.
    do_reset();
    req_i = 2'b10;
    set_cmd(1, 1'b0, 4'h4, 32'h0);
    step();
    step();
    req_i = 2'b01;
    uart_rvalid_i = 1'b0;
    step();
    req_i = 2'b00;
    uart_rvalid_i = 1'b1;
    rstn_i = 1'b0;
    #1;
    check("rstresp_rvalid", rvalid_o, 2'b00);
    do_reset();
    req_i = 2'b11;
    uart_rvalid_i = 1'b0;
    #1;
    check("rstresp_next_gnt", gnt_o, 2'b01);
    step();
    uart_rvalid_i = 1'b1;
    step();

    // Text lines: requester 0 sends "Hi\n" while requester 1 sends "XY".
    do_reset();
    s0[0] = 8'h48; s0[1] = 8'h69; s0[2] = 8'h0A;
    s1[0] = 8'h58; s1[1] = 8'h59;
    p0 = 0; p1 = 0;
    for (int i = 0; i < 40 && (p0 < 3 || p1 < 2); i++) begin
      req_i = {p1 < 2, p0 < 3};
      set_cmd(0, 1'b1, TX_ADDR, {24'h0, s0[p0 < 3 ? p0 : 2]});
      set_cmd(1, 1'b1, TX_ADDR, {24'h0, s1[p1 < 2 ? p1 : 1]});
      n = gq.size();
      step();
      if (gq.size() > n) begin
        if (gq[n] == 0) p0++;
        else            p1++;
      end
    end
    if (LOCK_EN) exp_order = '{0, 0, 0, 1, 1};
    else         exp_order = '{0, 1, 0, 1, 0};
    check("text_count", gq.size(), 5);
    for (int i = 0; i < 5 && i < gq.size(); i++) check("text_order", gq[i], exp_order[i]);

    // Requester 0 goes silent after 'H'; requester 1 waits out the lock.
    do_reset();
    req_i = 2'b01;
    set_cmd(0, 1'b1, TX_ADDR, 32'h48);
    set_cmd(1, 1'b1, TX_ADDR, 32'h5A);
    step();
    req_i = 2'b10;
    for (int i = 0; i < LOCK_TIMEOUT + 100 && gq.size() < 2; i++) step();
    check("timeout_grants", gq.size(), 2);
    if (gq.size() == 2) begin
      check("timeout_winner", gq[1], 1);
      check("timeout_gap", gcyc[1] - gcyc[0], LOCK_EN ? LOCK_TIMEOUT + 2 : 2);
    end
    req_i = 2'b00;
    step();

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      req_i = 2'($urandom_range(0, 3));
      for (int r = 0; r < 2; r++) begin
        we_i[r]    = 1'($urandom_range(0, 1));
        be_i[r]    = 4'($urandom);
        addr_i[r]  = ($urandom_range(0, 1) == 0) ? TX_ADDR : ADDR_WIDTH'($urandom);
        wdata_i[r] = $urandom;
        if ($urandom_range(0, 2) == 0) wdata_i[r][7:0] = 8'h0A;
      end
      uart_gnt_i    = ($urandom_range(0, 3) != 0);
      uart_rvalid_i = ($urandom_range(0, 4) < 3);
      uart_rdata_i  = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
